// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard controller: the controller FSM states,
// the execute-operand forwarding select encoding and the load-use stall preload.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // The first load-use stall cycle is spent in RUN, so the down-counter
    // covers the remaining cycles minus the final one spent at lu_cnt == 0.
    function automatic logic [1:0] lu_preload(input int cycles);
        return (cycles > 1) ? 2'(cycles - 2) : 2'd0;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one execute-stage operand: a non-load result in the
// memory stage wins over the writeback stage; register 0 never forwards.
module hazard_fwd_sel
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wen,
    input  logic             mem_is_load,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wen,
    output fwd_sel_t         sel
);

    // Youngest producer first; load data is not available in the memory stage.
    always_comb begin
        sel = FWD_RF;
        if (mem_wen && !mem_is_load && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_wen && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: PC / pipeline-register enables, bubble flushes,
// operand forwarding selects and a saturating hazard-stall counter.
// Build option: define HAZARD_FORWARD_EN to enable operand forwarding; without
// it every decode source that matches a pending ex/mem write stalls decode.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int REG_W           = 5,
    parameter int CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wen,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_wen,
    input  logic             mem_is_load,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wen,
    input  logic             branch_taken,
    output logic             pcEN,
    output logic             fdEN,
    output logic             dxEN,
    output logic             xmEN,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] LU_PRELOAD = lu_preload(LOAD_USE_CYCLES);

    hz_state_t  state;
    hz_state_t  ret_state;
    hz_state_t  eff_state;
    logic [1:0] lu_cnt;
    logic       br_pend;
    logic       mem_wait;
    logic       redirect;
    logic       luh;
    logic       data_haz;
    logic       hz_stall;
    logic       lu_go;
    logic       count_en;

    // A writer hits decode when it targets a nonzero register that decode reads.
    function automatic logic src_hit(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rt);
        return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    assign luh = ex_is_load & ex_wen & src_hit(ex_rd, dec_rs, dec_rt, dec_uses_rt);

`ifdef HAZARD_FORWARD_EN
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .src(ex_rs), .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .sel(sel_a)
    );

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .src(ex_rt), .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .sel(sel_b)
    );

    assign fwd_a    = sel_a;
    assign fwd_b    = sel_b;
    assign data_haz = luh;
`else
    logic unused_fwd_inputs;

    // Without bypass paths, any in-flight producer of a decode source stalls it.
    assign fwd_a    = FWD_RF;
    assign fwd_b    = FWD_RF;
    assign data_haz = luh
                    | (ex_wen  & src_hit(ex_rd,  dec_rs, dec_rt, dec_uses_rt))
                    | (mem_wen & src_hit(mem_rd, dec_rs, dec_rt, dec_uses_rt));
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, mem_is_load, wb_rd, wb_wen};
`endif

    // While waiting on memory, the saved state decides what happens once dhit arrives.
    assign mem_wait  = dmem_req & ~dhit;
    assign redirect  = branch_taken | br_pend;
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;
    assign hz_stall  = (eff_state == RUN) & data_haz & ihit;
    assign lu_go     = hz_stall & luh & (LOAD_USE_CYCLES > 1);

    // Enables and flushes by priority: memory wait, redirect, stall, advance.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        pcEN     = ihit;
        fdEN     = ihit;
        dxEN     = 1'b1;
        xmEN     = 1'b1;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        count_en = 1'b0;
        if (mem_wait) begin
            pcEN     = 1'b0;
            fdEN     = 1'b0;
            dxEN     = 1'b0;
            xmEN     = 1'b0;
            count_en = 1'b1;
        end else if (redirect) begin
            // Without the fetch the redirect cannot land; freeze and keep it pending.
            pcEN     = ihit;
            fdEN     = ihit;
            dxEN     = ihit;
            xmEN     = ihit;
            fd_flush = ihit;
            dx_flush = ihit;
        end else if ((eff_state == LU_STALL) || hz_stall) begin
            pcEN     = 1'b0;
            fdEN     = 1'b0;
            dx_flush = 1'b1;
            count_en = 1'b1;
        end
    end

    // FSM, load-use down-counter, pending redirect and saturating stall counter.
    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            ret_state   <= RUN;
            lu_cnt      <= 2'd0;
            br_pend     <= 1'b0;
            stall_count <= '0;
        end else begin
            if (count_en && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (mem_wait) begin
                state <= MEM_WAIT;
                if (state != MEM_WAIT) begin
                    ret_state <= state;
                end
            end else if (redirect) begin
                state   <= RUN;
                lu_cnt  <= 2'd0;
                br_pend <= ~ihit;
            end else if (eff_state == LU_STALL) begin
                if (lu_cnt == 2'd0) begin
                    state <= RUN;
                end else begin
                    state  <= LU_STALL;
                    lu_cnt <= lu_cnt - 2'd1;
                end
            end else if (lu_go) begin
                state  <= LU_STALL;
                lu_cnt <= LU_PRELOAD;
            end else begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share stimulus:
// instance a uses LOAD_USE_CYCLES=1, CNT_W=16; instance b uses LOAD_USE_CYCLES=3,
// CNT_W=4. Expected values come from vector tables, hand sequences and a
// cycle-level reference model built on "remaining stall cycles" bookkeeping.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;

    // Output vector layout: {pcEN, fdEN, dxEN, xmEN, fd_flush, dx_flush, fwd_a, fwd_b}
    localparam logic [9:0] V_RUN   = 10'b1111_00_00_00;
    localparam logic [9:0] V_IDLE  = 10'b0011_00_00_00;
    localparam logic [9:0] V_STALL = 10'b0011_01_00_00;
    localparam logic [9:0] V_BR    = 10'b1111_11_00_00;
    localparam logic [9:0] V_ZERO  = 10'b0000_00_00_00;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    logic ihit, dhit, dmem_req, branch_taken;
    logic dec_uses_rt, ex_wen, ex_is_load, mem_wen, mem_is_load, wb_wen;
    logic [REG_W-1:0] dec_rs, dec_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;

    logic a_pc, a_fd, a_dx, a_xm, a_fdf, a_dxf;
    logic b_pc, b_fd, b_dx, b_xm, b_fdf, b_dxf;
    logic [1:0] a_fa, a_fb, b_fa, b_fb;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [9:0]  act_a, act_b;

    assign act_a = {a_pc, a_fd, a_dx, a_xm, a_fdf, a_dxf, a_fa, a_fb};
    assign act_b = {b_pc, b_fd, b_dx, b_xm, b_fdf, b_dxf, b_fa, b_fb};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance
    int m_rem[2];
    int m_cnt[2];
    bit m_pend[2];

    typedef struct {
        string      name;
        logic [3:0] ctl;   // {ihit, dmem_req, dhit, branch_taken}
        logic [4:0] drs, drt;
        logic       urt;
        logic [4:0] xrs, xrt, xrd;
        logic       xw, xl;
        logic [4:0] mrd;
        logic       mw, ml;
        logic [4:0] wrd;
        logic       ww;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(1), .REG_W(REG_W), .CNT_W(16)) u_dut_a (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .branch_taken(branch_taken),
        .pcEN(a_pc), .fdEN(a_fd), .dxEN(a_dx), .xmEN(a_xm),
        .fd_flush(a_fdf), .dx_flush(a_dxf), .fwd_a(a_fa), .fwd_b(a_fb),
        .stall_count(cnt_a)
    );

    pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(3), .REG_W(REG_W), .CNT_W(4)) u_dut_b (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_is_load(mem_is_load),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .branch_taken(branch_taken),
        .pcEN(b_pc), .fdEN(b_fd), .dxEN(b_dx), .xmEN(b_xm),
        .fd_flush(b_fdf), .dx_flush(b_dxf), .fwd_a(b_fa), .fwd_b(b_fb),
        .stall_count(cnt_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] act_of(input int i);
        return (i == 0) ? {22'b0, act_a} : {22'b0, act_b};
    endfunction

    function automatic logic [31:0] cnt_of(input int i);
        return (i == 0) ? {16'b0, cnt_a} : {28'b0, cnt_b};
    endfunction

    function automatic int luc_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    // Does a pending write to rd feed a source the decode instruction reads?
    function automatic bit reads_reg(input logic [4:0] rd);
        return (rd != 0) && ((rd == dec_rs) || (dec_uses_rt && (rd == dec_rt)));
    endfunction

    function automatic bit ref_luh();
        return ex_is_load && ex_wen && reads_reg(ex_rd);
    endfunction

    function automatic bit ref_hazard();
`ifdef HAZARD_FORWARD_EN
        return ref_luh();
`else
        return ref_luh() || (ex_wen && reads_reg(ex_rd)) || (mem_wen && reads_reg(mem_rd));
`endif
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
`ifdef HAZARD_FORWARD_EN
        if (src != 0 && mem_wen && !mem_is_load && mem_rd == src) return 2'b01;
        if (src != 0 && wb_wen && wb_rd == src) return 2'b10;
        return 2'b00;
`else
        return (src == 5'd31) ? 2'b00 : 2'b00;
`endif
    endfunction

    // Compare both instances with the model for the current cycle, then advance the model.
    task automatic model_cmp(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic [5:0] c;
            logic [9:0] e;
            bit stl;
            check($sformatf("%s_cnt%0d", tag, i), cnt_of(i), 32'(m_cnt[i]));
            stl = 0;
            if (dmem_req && !dhit) begin
                c = 6'b000000;
                stl = 1;
            end else if (branch_taken || m_pend[i]) begin
                c = ihit ? 6'b111111 : 6'b000000;
                m_pend[i] = !ihit;
                m_rem[i] = 0;
            end else if (m_rem[i] > 0) begin
                c = 6'b001101;
                stl = 1;
                m_rem[i]--;
            end else if (ihit && ref_hazard()) begin
                c = 6'b001101;
                stl = 1;
                m_rem[i] = ref_luh() ? luc_of(i) - 1 : 0;
            end else begin
                c = {ihit, ihit, 4'b1100};
            end
            e = {c, ref_fwd(ex_rs), ref_fwd(ex_rt)};
            check($sformatf("%s_out%0d", tag, i), act_of(i), {22'b0, e});
            if (stl && m_cnt[i] < cmax_of(i)) m_cnt[i]++;
        end
    endtask

    task automatic quiet();
        ihit = 1; dhit = 0; dmem_req = 0; branch_taken = 0;
        dec_rs = 0; dec_rt = 0; dec_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_wen = 0; ex_is_load = 0;
        mem_rd = 0; mem_wen = 0; mem_is_load = 0; wb_rd = 0; wb_wen = 0;
    endtask

    task automatic luh_on();
        ex_rd = 5'd3; ex_wen = 1; ex_is_load = 1; dec_rs = 5'd3;
    endtask

    // Asynchronous reset: counters must clear at once, release on a falling edge.
    task automatic do_reset();
        quiet();
        nRST = 0;
        #1;
        check("rst_cnt_a", {16'b0, cnt_a}, 32'd0);
        check("rst_cnt_b", {28'b0, cnt_b}, 32'd0);
        @(negedge CLK);
        nRST = 1;
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
        end
    endtask

    // One cycle with explicit expectations (count checks skipped when negative).
    task automatic cyc(input string nm, input logic [9:0] ea, input logic [9:0] eb,
                       input int ca, input int cb);
        #2;
        check({nm, "_a"}, {22'b0, act_a}, {22'b0, ea});
        check({nm, "_b"}, {22'b0, act_b}, {22'b0, eb});
        if (ca >= 0) check({nm, "_cnt_a"}, {16'b0, cnt_a}, 32'(ca));
        if (cb >= 0) check({nm, "_cnt_b"}, {28'b0, cnt_b}, 32'(cb));
        model_cmp(nm);
        @(negedge CLK);
    endtask

    function automatic vec_t mk(input string nm, input logic [3:0] ctl,
                                input logic [4:0] drs, input logic [4:0] drt, input logic urt,
                                input logic [4:0] xrs, input logic [4:0] xrt, input logic [4:0] xrd,
                                input logic xw, input logic xl,
                                input logic [4:0] mrd, input logic mw, input logic ml,
                                input logic [4:0] wrd, input logic ww, input logic [9:0] e);
        vec_t v;
        v.name = nm; v.ctl = ctl; v.drs = drs; v.drt = drt; v.urt = urt;
        v.xrs = xrs; v.xrt = xrt; v.xrd = xrd; v.xw = xw; v.xl = xl;
        v.mrd = mrd; v.mw = mw; v.ml = ml; v.wrd = wrd; v.ww = ww; v.exp = e;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v);
        {ihit, dmem_req, dhit, branch_taken} = v.ctl;
        dec_rs = v.drs; dec_rt = v.drt; dec_uses_rt = v.urt;
        ex_rs = v.xrs; ex_rt = v.xrt; ex_rd = v.xrd; ex_wen = v.xw; ex_is_load = v.xl;
        mem_rd = v.mrd; mem_wen = v.mw; mem_is_load = v.ml; wb_rd = v.wrd; wb_wen = v.ww;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               name         ctl      drs drt urt xrs xrt xrd xw xl mrd mw ml wrd ww exp
        vecs.push_back(mk("run_adv",  4'b1000, 1,  2,  1,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, V_RUN));
        vecs.push_back(mk("imiss",    4'b0000, 1,  2,  1,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, V_IDLE));
        vecs.push_back(mk("luh_rs",   4'b1000, 3,  0,  0,  0,  0,  3,  1, 1, 0,  0, 0, 0,  0, V_STALL));
        vecs.push_back(mk("luh_rt",   4'b1000, 1,  4,  1,  0,  0,  4,  1, 1, 0,  0, 0, 0,  0, V_STALL));
        vecs.push_back(mk("rt_nosrc", 4'b1000, 1,  4,  0,  0,  0,  4,  1, 1, 0,  0, 0, 0,  0, V_RUN));
        vecs.push_back(mk("load_r0",  4'b1000, 0,  0,  1,  0,  0,  0,  1, 1, 0,  0, 0, 0,  0, V_RUN));
        vecs.push_back(mk("load_nowen",4'b1000,3,  0,  0,  0,  0,  3,  0, 1, 0,  0, 0, 0,  0, V_RUN));
        vecs.push_back(mk("mem_wait", 4'b1100, 0,  0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, V_ZERO));
        vecs.push_back(mk("mem_done", 4'b1110, 0,  0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, V_RUN));
        vecs.push_back(mk("branch",   4'b1001, 0,  0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, V_BR));
        vecs.push_back(mk("br_ovr_luh",4'b1001,3,  0,  0,  0,  0,  3,  1, 1, 0,  0, 0, 0,  0, V_BR));
        vecs.push_back(mk("mw_ovr_br",4'b1101, 0,  0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, V_ZERO));
        vecs.push_back(mk("br_imiss", 4'b0001, 0,  0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 0,  0, V_ZERO));
`ifdef HAZARD_FORWARD_EN
        vecs.push_back(mk("alu_ex",   4'b1000, 5,  0,  0,  0,  0,  5,  1, 0, 0,  0, 0, 0,  0, V_RUN));
        vecs.push_back(mk("alu_mem",  4'b1000, 0,  6,  1,  0,  0,  0,  0, 0, 6,  1, 0, 0,  0, V_RUN));
        vecs.push_back(mk("fwd_mem",  4'b1000, 0,  0,  0,  5,  0,  0,  0, 0, 5,  1, 0, 5,  1, V_RUN | 10'b0000_00_01_00));
        vecs.push_back(mk("fwd_wb_b", 4'b1000, 0,  0,  0,  0,  7,  0,  0, 0, 0,  0, 0, 7,  1, V_RUN | 10'b0000_00_00_10));
        vecs.push_back(mk("fwd_ldmem",4'b1000, 0,  0,  0,  5,  0,  0,  0, 0, 5,  1, 1, 5,  1, V_RUN | 10'b0000_00_10_00));
`else
        vecs.push_back(mk("alu_ex",   4'b1000, 5,  0,  0,  0,  0,  5,  1, 0, 0,  0, 0, 0,  0, V_STALL));
        vecs.push_back(mk("alu_mem",  4'b1000, 0,  6,  1,  0,  0,  0,  0, 0, 6,  1, 0, 0,  0, V_STALL));
        vecs.push_back(mk("fwd_mem",  4'b1000, 0,  0,  0,  5,  0,  0,  0, 0, 5,  1, 0, 5,  1, V_RUN));
        vecs.push_back(mk("fwd_wb_b", 4'b1000, 0,  0,  0,  0,  7,  0,  0, 0, 0,  0, 0, 7,  1, V_RUN));
        vecs.push_back(mk("fwd_ldmem",4'b1000, 0,  0,  0,  5,  0,  0,  0, 0, 5,  1, 1, 5,  1, V_RUN));
`endif
        vecs.push_back(mk("fwd_r0",   4'b1000, 0,  0,  0,  0,  0,  0,  0, 0, 0,  1, 0, 0,  1, V_RUN));

        // Single-cycle decisions from the reset state
        foreach (vecs[k]) begin
            do_reset();
            apply_vec(vecs[k]);
            cyc(vecs[k].name, vecs[k].exp, vecs[k].exp, -1, -1);
        end

        // Load-use: one stall cycle on a, three on b
        do_reset();
        luh_on();
        cyc("lu0", V_STALL, V_STALL, 0, 0);
        quiet();
        cyc("lu1", V_RUN, V_STALL, 1, 1);
        cyc("lu2", V_RUN, V_STALL, 1, 2);
        cyc("lu3", V_RUN, V_RUN, 1, 3);

        // Branch in the second stall cycle aborts the stall
        do_reset();
        luh_on();
        cyc("br0", V_STALL, V_STALL, 0, 0);
        quiet();
        branch_taken = 1;
        cyc("br1", V_BR, V_BR, 1, 1);
        branch_taken = 0;
        cyc("br2", V_RUN, V_RUN, 1, 1);

        // Memory wait during the stall freezes it, then the stall resumes
        do_reset();
        luh_on();
        cyc("mw0", V_STALL, V_STALL, 0, 0);
        quiet();
        dmem_req = 1;
        dhit = 0;
        for (int k = 0; k < 4; k++) cyc("mw_wait", V_ZERO, V_ZERO, -1, -1);
        dhit = 1;
        cyc("mw5", V_RUN, V_STALL, 5, 5);
        dmem_req = 0;
        dhit = 0;
        cyc("mw6", V_RUN, V_STALL, 5, 6);
        cyc("mw7", V_RUN, V_RUN, 5, 7);

        // Redirect seen during an ifetch miss is held until the fetch lands
        do_reset();
        branch_taken = 1;
        ihit = 0;
        cyc("bp0", V_ZERO, V_ZERO, 0, 0);
        branch_taken = 0;
        cyc("bp1", V_ZERO, V_ZERO, 0, 0);
        ihit = 1;
        cyc("bp2", V_BR, V_BR, 0, 0);
        cyc("bp3", V_RUN, V_RUN, 0, 0);

        // Counter saturation on the 4-bit instance, then reset mid-stall
        do_reset();
        luh_on();
        for (int k = 0; k < 20; k++) cyc("sat", V_STALL, V_STALL, -1, -1);
        cyc("sat_cnt", V_STALL, V_STALL, 20, 15);
        do_reset();
        cyc("post_rst", V_RUN, V_RUN, 0, 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            ihit         = ($urandom_range(0, 9) < 8);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dhit         = $urandom_range(0, 1) != 0;
            branch_taken = ($urandom_range(0, 9) == 0);
            dec_rs       = 5'($urandom_range(0, 3));
            dec_rt       = 5'($urandom_range(0, 3));
            dec_uses_rt  = $urandom_range(0, 1) != 0;
            ex_rs        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            ex_wen       = $urandom_range(0, 1) != 0;
            ex_is_load   = $urandom_range(0, 1) != 0;
            mem_rd       = 5'($urandom_range(0, 3));
            mem_wen      = $urandom_range(0, 1) != 0;
            mem_is_load  = $urandom_range(0, 1) != 0;
            wb_rd        = 5'($urandom_range(0, 3));
            wb_wen       = $urandom_range(0, 1) != 0;
            #2;
            model_cmp("rnd");
            @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_USE_CYCLES, default 1, decode-stall cycles per load-use hazard (legal 1..4).
REQ-002 SHALL have parameter REG_W, default 5, register-address width.
REQ-003 SHALL have parameter CNT_W, default 16, stall performance-counter width.
REQ-004 CLK  in  1  clock; all state rising-edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 ihit, dhit  in  1 each  instruction-fetch hit, data-access complete.
REQ-007 dmem_req  in  1  memory stage has a load/store outstanding.
REQ-008 dec_rs, dec_rt  in  REG_W each  decode-stage sources; dec_uses_rt  in  1  rt is a true source.
REQ-009 ex_rs, ex_rt, ex_rd  in  REG_W each; ex_wen, ex_is_load  in  1 each  execute-stage fields.
REQ-010 mem_rd  in  REG_W; mem_wen, mem_is_load  in  1 each  memory-stage fields.
REQ-011 wb_rd  in  REG_W; wb_wen  in  1  writeback-stage fields.
REQ-012 branch_taken  in  1  execute stage resolved a redirect this cycle.
REQ-013 pcEN, fdEN, dxEN, xmEN  out  1 each  PC and pipeline-register enables.
REQ-014 fd_flush, dx_flush  out  1 each  bubble insert into IF/ID, ID/EX.
REQ-015 fwd_a, fwd_b  out  2 each  execute operand select: 00 regfile, 01 mem, 10 wb.
REQ-016 stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-017 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT, with a registered return state and down-counter lu_cnt (2 bits).
REQ-018 Load-use hazard (luh) SHALL be ex_is_load & ex_wen & ex_rd!=0 & (ex_rd==dec_rs | (dec_uses_rt & ex_rd==dec_rt)).
REQ-019 Priority per cycle SHALL be: memory wait > branch_taken > luh/stall > normal advance.
REQ-020 Memory wait (dmem_req & !dhit) SHALL drive all enables 0, both flushes 0, enter MEM_WAIT saving current state; lu_cnt frozen.
REQ-021 MEM_WAIT SHALL return to the saved state on the cycle dhit rises; that cycle's outputs follow the saved state's rules.
REQ-022 RUN, no hazard: pcEN=fdEN=ihit, dxEN=xmEN=1, flushes 0.
REQ-023 RUN with luh & ihit: pcEN=fdEN=0, dx_flush=1; if LOAD_USE_CYCLES>1 load lu_cnt=LOAD_USE_CYCLES-2, go LU_STALL; else stay RUN.
REQ-024 LU_STALL: pcEN=fdEN=0, dx_flush=1 each cycle; lu_cnt decrements; at lu_cnt==0 return to RUN next cycle.
REQ-025 branch_taken & ihit in RUN or LU_STALL: pcEN=1, fdEN=1, fd_flush=1, dx_flush=1, next state RUN (aborts stall).
REQ-026 branch_taken with ihit=0: pcEN=fdEN=0, flushes held until ihit; redirect not lost.
REQ-027 Register 0 SHALL never match for hazard or forwarding.
REQ-028 stall_count SHALL increment each cycle pcEN=0 caused by luh, LU_STALL or MEM_WAIT (not ihit=0), saturating at all-ones.
REQ-029 Outputs other than stall_count and FSM state SHALL be combinational from inputs and state; no added latency.

Reset
REQ-030 nRST low SHALL force state RUN, lu_cnt=0, return state RUN, stall_count=0 immediately.
REQ-031 Reset mid-stall or mid-wait SHALL abandon it; first cycle after release behaves as RUN.

Configuration
REQ-032 Macro HAZARD_FORWARD_EN defined: fwd_a/fwd_b select mem (mem_wen, mem_rd!=0, !mem_is_load, match) else wb (wb_wen, wb_rd!=0, match) else regfile.
REQ-033 HAZARD_FORWARD_EN undefined: fwd_a=fwd_b=00; any decode source matching writing ex_rd or mem_rd (nonzero) stalls as REQ-023 for one cycle per occurrence.

Structure
REQ-034 FSM state enum, fwd select encoding (FWD_RF/FWD_MEM/FWD_WB) SHALL live in cpu_types_pkg.
REQ-035 Forwarding comparator SHALL be sub-module hazard_fwd_sel, instantiated per operand.

Verification
REQ-036 LOAD_USE_CYCLES=1: ex lw r3, dec add uses r3, ihit=1 -> one cycle pcEN=0, dx_flush=1, stall_count=1.
REQ-037 LOAD_USE_CYCLES=3: same hazard -> three stall cycles, RUN on fourth, stall_count=3.
REQ-038 LOAD_USE_CYCLES=3, branch_taken in second stall cycle -> fd_flush=dx_flush=1, pcEN=1, RUN next.
REQ-039 dmem_req=1, dhit low 4 cycles during LU_STALL -> enables 0, lu_cnt frozen, resumes stall after dhit.
REQ-040 FORWARD_EN: mem_rd=5 wen, wb_rd=5 wen, ex_rs=5 -> fwd_a=01; ex_rd=0 load -> no stall.
REQ-041 CNT_W=4, 20 stall cycles -> stall_count=15; nRST pulse mid-stall -> count 0, state RUN.
